// File: rtl/dp_issue_ctrl_pkg.sv
// Shared definitions for the ARM data-processing issue/retire controller:
// opcode and condition encodings, ALU op codes, CPSR flag bit positions,
// FSM state encoding and opcode classification helpers.
package dp_issue_ctrl_pkg;

    // FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // 4-bit data-processing opcodes (inst[24:21])
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RSC = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // ALU op that passes B through and has no flag meaning; parked value
    localparam logic [4:0] ALU_OP_PASS_B = 5'b10000;

    // Condition codes (inst[31:28])
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Flag bit positions, shared by alu_flag and cpsr_flag ({C,Z,V,N})
    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // TST/TEQ/CMP/CMN: always set flags, never write back
    function automatic logic is_compare(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

    // Logical ops take C from the shifter and leave V alone
    function automatic logic is_logical(input logic [3:0] op);
        logic r;
        case (op)
            OP_AND, OP_EOR, OP_TST, OP_TEQ,
            OP_ORR, OP_MOV, OP_BIC, OP_MVN: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dp_issue_ctrl_cond_check.sv
// Combinational ARM condition-field evaluator against a {C,Z,V,N} flag vector.
module dp_cond_check
    import dp_issue_ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);

    logic c, z, v, n;

    assign c = flags_i[FLAG_C];
    assign z = flags_i[FLAG_Z];
    assign v = flags_i[FLAG_V];
    assign n = flags_i[FLAG_N];

    // Decode the condition field; NV (1111) never passes
    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = !z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = !c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = !n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = !v;
            COND_HI: pass_o = c && !z;
            COND_LS: pass_o = !c || z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = !z && (n == v);
            COND_LE: pass_o = z || (n != v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/dp_issue_ctrl.sv
// Issue/retire controller in front of the 32-bit ARM ALU. Takes one
// data-processing instruction at a time, gates it on its condition field,
// drives registered ALU operands, captures the result and flags after one
// EXEC cycle, owns CPSR NZCV and presents the result to writeback.
module dp_issue_ctrl
    import dp_issue_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst,
    input  logic [31:0] rn_data,
    input  logic [31:0] shifter_op,
    input  logic        shifter_cout,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_cin,
    output logic [4:0]  alu_op,
    input  logic [31:0] alu_r,
    input  logic [3:0]  alu_flag,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [3:0]  cpsr_flag,
    output logic        cond_fail,
    output logic        illegal
);

    state_e      state_q, state_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic        alu_cin_q, alu_cin_d;
    logic [4:0]  alu_op_q, alu_op_d;
    logic        s_q, s_d;
    logic [3:0]  rd_q, rd_d;
    logic        sh_cout_q, sh_cout_d;
    logic        wb_valid_q, wb_valid_d;
    logic [3:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [3:0]  cpsr_q, cpsr_d;
    logic        cond_fail_q, cond_fail_d;
    logic        illegal_q, illegal_d;

    logic        cond_pass;
    logic [3:0]  exec_op;
    logic        enc_illegal;

    // Instruction bits this block has no use for (immediate flag, Rn index,
    // operand2 encoding) -- operands arrive already resolved.
    logic        unused_inst_bits;
    assign unused_inst_bits = ^{inst[25], inst[19:16], inst[11:0]};

    // While in EXEC the latched ALU op still carries the DP opcode
    assign exec_op     = alu_op_q[3:0];
    assign enc_illegal = (inst[27:26] != 2'b00);

    // Condition evaluated against the committed flags only (no forwarding)
    dp_cond_check u_cond (
        .cond_i  (inst[31:28]),
        .flags_i (cpsr_q),
        .pass_o  (cond_pass)
    );

    // Next-state and datapath control; pulses default low every cycle
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cin_d   = alu_cin_q;
        alu_op_d    = alu_op_q;
        s_d         = s_q;
        rd_d        = rd_q;
        sh_cout_d   = sh_cout_q;
        wb_valid_d  = wb_valid_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        cpsr_d      = cpsr_q;
        cond_fail_d = 1'b0;
        illegal_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (inst_valid) begin
                    if (enc_illegal) begin
                        illegal_d = 1'b1;
                    end else if (!cond_pass) begin
                        cond_fail_d = 1'b1;
                    end else begin
                        alu_a_d   = shifter_op;
                        alu_b_d   = rn_data;
                        alu_cin_d = cpsr_q[FLAG_C];
                        alu_op_d  = {1'b0, inst[24:21]};
                        s_d       = inst[20];
                        rd_d      = inst[15:12];
                        sh_cout_d = shifter_cout;
                        state_d   = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                wb_data_d = alu_r;
                alu_op_d  = ALU_OP_PASS_B;
                if (s_q || is_compare(exec_op)) begin
                    if (is_logical(exec_op)) begin
                        cpsr_d[FLAG_N] = alu_flag[FLAG_N];
                        cpsr_d[FLAG_Z] = alu_flag[FLAG_Z];
                        cpsr_d[FLAG_C] = sh_cout_q;
                    end else begin
                        cpsr_d = alu_flag;
                    end
                end
                if (is_compare(exec_op)) begin
                    state_d = ST_IDLE;
                end else begin
                    wb_rd_d    = rd_q;
                    wb_valid_d = 1'b1;
                    state_d    = ST_WB;
                end
            end

            ST_WB: begin
                if (wb_ready) begin
                    wb_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset discards whatever instruction is in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            alu_op_q    <= ALU_OP_PASS_B;
            s_q         <= 1'b0;
            rd_q        <= '0;
            sh_cout_q   <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            cpsr_q      <= '0;
            cond_fail_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            alu_op_q    <= alu_op_d;
            s_q         <= s_d;
            rd_q        <= rd_d;
            sh_cout_q   <= sh_cout_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            cpsr_q      <= cpsr_d;
            cond_fail_q <= cond_fail_d;
            illegal_q   <= illegal_d;
        end
    end

    assign inst_ready = (state_q == ST_IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_cin    = alu_cin_q;
    assign alu_op     = alu_op_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign cpsr_flag  = cpsr_q;
    assign cond_fail  = cond_fail_q;
    assign illegal    = illegal_q;

endmodule
